// File: rtl/exe_alu_stage.sv
// Execute-stage ALU: data-processing ops, NZCV status register and, when the
// MUL_UNIT_EN macro is defined, a 32-cycle iterative shift-add multiplier.
module exe_alu_stage #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid_in,
   output logic                  o_ready_out,
   input  logic [3:0]            i_exe_cmd,
   input  logic                  i_s_bit,
   input  logic [WORD_WIDTH-1:0] i_val1,
   input  logic [WORD_WIDTH-1:0] i_val2,
   output logic [WORD_WIDTH-1:0] o_result,
   output logic                  o_result_valid,
   output logic [3:0]            o_status_out,
   output logic                  o_dbg_state
);

   // Handshake: an operation is taken on a rising edge where i_valid_in and
   // o_ready_out are both 1; o_ready_out depends only on the FSM state, and
   // o_result_valid pulses for one cycle whenever o_result carries a new value.

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MUL = 4'b1010;
   localparam int         MSB     = WORD_WIDTH - 1;

   logic [WORD_WIDTH-1:0] r_result;
   logic                  r_result_valid;
   logic [3:0]            r_status;

   logic                  w_accept;
   logic                  w_accept_alu;
   logic [WORD_WIDTH-1:0] w_add_b;
   logic                  w_add_cin;
   logic [WORD_WIDTH:0]   w_sum;
   logic                  w_sum_ovf;
   logic [WORD_WIDTH-1:0] w_alu_result;
   logic                  w_alu_c;
   logic                  w_alu_v;
   logic [3:0]            w_alu_flags;

   assign w_accept = i_valid_in & o_ready_out;

   // Subtraction is a + ~b + carry-in, so the adder's carry-out is NOT borrow.
   always_comb begin
      w_add_b   = i_val2;
      w_add_cin = 1'b0;
      case (i_exe_cmd)
         CMD_ADC: w_add_cin = r_status[1];
         CMD_SUB: begin
            w_add_b   = ~i_val2;
            w_add_cin = 1'b1;
         end
         CMD_SBC: begin
            w_add_b   = ~i_val2;
            w_add_cin = r_status[1];
         end
         default: ;
      endcase
   end

   assign w_sum     = {1'b0, i_val1} + {1'b0, w_add_b} + {{WORD_WIDTH{1'b0}}, w_add_cin};
   assign w_sum_ovf = (i_val1[MSB] == w_add_b[MSB]) && (w_sum[MSB] != i_val1[MSB]);

   always_comb begin
      w_alu_result = '0;
      w_alu_c      = r_status[1];
      w_alu_v      = r_status[0];
      case (i_exe_cmd)
         CMD_MOV: w_alu_result = i_val2;
         CMD_MVN: w_alu_result = ~i_val2;
         CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
            w_alu_result = w_sum[MSB:0];
            w_alu_c      = w_sum[WORD_WIDTH];
            w_alu_v      = w_sum_ovf;
         end
         CMD_AND: w_alu_result = i_val1 & i_val2;
         CMD_ORR: w_alu_result = i_val1 | i_val2;
         CMD_EOR: w_alu_result = i_val1 ^ i_val2;
         default: w_alu_result = '0;
      endcase
   end

   assign w_alu_flags = {w_alu_result[MSB], (w_alu_result == '0), w_alu_c, w_alu_v};

`ifdef MUL_UNIT_EN
   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [WORD_WIDTH-1:0] r_mcand;
   logic [WORD_WIDTH-1:0] r_mplier;
   logic [WORD_WIDTH-1:0] r_acc;
   logic [4:0]            r_cnt;
   logic                  r_mul_s;
   logic                  w_start_mul;
   logic                  w_mul_done;
   logic [WORD_WIDTH-1:0] w_acc_next;

   assign w_start_mul  = w_accept && (i_exe_cmd == CMD_MUL);
   assign w_accept_alu = w_accept && (i_exe_cmd != CMD_MUL);
   assign w_mul_done   = (r_state == ST_MUL_BUSY) && (r_cnt == 5'd31);
   assign w_acc_next   = r_acc + (r_mplier[r_cnt] ? (r_mcand << r_cnt) : '0);
   assign o_dbg_state  = r_state;

   always_ff @(posedge i_clk) begin
      if (!i_rst) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      o_ready_out  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_ready_out = 1'b1;
            if (w_start_mul) w_state_next = ST_MUL_BUSY;
         end
         ST_MUL_BUSY: begin
            if (w_mul_done) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end
`else
   assign w_accept_alu = w_accept;
   assign o_ready_out  = 1'b1;
   assign o_dbg_state  = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_status       <= 4'b0000;
`ifdef MUL_UNIT_EN
         r_mcand        <= '0;
         r_mplier       <= '0;
         r_acc          <= '0;
         r_cnt          <= 5'd0;
         r_mul_s        <= 1'b0;
`endif
      end else begin
         r_result_valid <= 1'b0;
         if (w_accept_alu) begin
            r_result       <= w_alu_result;
            r_result_valid <= 1'b1;
            if (i_s_bit) r_status <= w_alu_flags;
         end
`ifdef MUL_UNIT_EN
         if (w_start_mul) begin
            r_mcand  <= i_val1;
            r_mplier <= i_val2;
            r_mul_s  <= i_s_bit;
            r_acc    <= '0;
            r_cnt    <= 5'd0;
         end
         // One multiplier bit per busy edge; the last bit delivers the product.
         if (r_state == ST_MUL_BUSY) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (w_mul_done) begin
               r_result       <= w_acc_next;
               r_result_valid <= 1'b1;
               if (r_mul_s) r_status <= {w_acc_next[MSB], (w_acc_next == '0), r_status[1:0]};
            end
         end
`endif
      end
   end

   assign o_result       = r_result;
   assign o_result_valid = r_result_valid;
   assign o_status_out   = r_status;

endmodule

// File: tb/tb_exe_alu_stage.sv
// Bench for exe_alu_stage: directed test-plan steps plus randomized ops checked
// against an arithmetic reference model; follows MUL_UNIT_EN like the design.
module tb_exe_alu_stage;

   localparam logic [3:0] C_MOV = 4'b0001;
   localparam logic [3:0] C_MVN = 4'b1001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_ADC = 4'b0011;
   localparam logic [3:0] C_SUB = 4'b0100;
   localparam logic [3:0] C_SBC = 4'b0101;
   localparam logic [3:0] C_AND = 4'b0110;
   localparam logic [3:0] C_ORR = 4'b0111;
   localparam logic [3:0] C_EOR = 4'b1000;
   localparam logic [3:0] C_MUL = 4'b1010;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic        ready_out;
   logic [3:0]  exe_cmd;
   logic        s_bit;
   logic [31:0] val1;
   logic [31:0] val2;
   logic [31:0] result;
   logic        result_valid;
   logic [3:0]  status_out;
   logic        dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [3:0]  exp_status;
   logic [31:0] exp_q[$];

   exe_alu_stage #(.WORD_WIDTH(32)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_valid_in     (valid_in),
      .o_ready_out    (ready_out),
      .i_exe_cmd      (exe_cmd),
      .i_s_bit        (s_bit),
      .i_val1         (val1),
      .i_val2         (val2),
      .o_result       (result),
      .o_result_valid (result_valid),
      .o_status_out   (status_out),
      .o_dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic ovf(input longint v);
      return (v > 64'sd2147483647) || (v < -64'sd2147483648);
   endfunction

   // Reference model: true-width integer arithmetic, updates exp_status when s=1.
   task automatic model(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r);
      longint ua, ub, sa, sb, uf, sf;
      int     ia, ib;
      logic   c, v, cin;
      ua = a; ub = b; ia = a; ib = b; sa = ia; sb = ib;
      cin = exp_status[1]; c = exp_status[1]; v = exp_status[0];
      r = 32'h0;
      case (cmd)
         C_MOV: r = b;
         C_MVN: r = ~b;
         C_ADD: begin uf = ua + ub; r = uf[31:0]; c = uf[32]; sf = sa + sb; v = ovf(sf); end
         C_ADC: begin uf = ua + ub + cin; r = uf[31:0]; c = uf[32]; sf = sa + sb + cin; v = ovf(sf); end
         C_SUB: begin r = a - b; c = (ua >= ub); sf = sa - sb; v = ovf(sf); end
         C_SBC: begin
            r = a - b - {31'b0, ~cin};
            c = (ua >= ub + (cin ? 0 : 1));
            sf = sa - sb - (cin ? 0 : 1);
            v = ovf(sf);
         end
         C_AND: r = a & b;
         C_ORR: r = a | b;
         C_EOR: r = a ^ b;
`ifdef MUL_UNIT_EN
         C_MUL: r = a * b;
`endif
         default: r = 32'h0;
      endcase
      if (s) exp_status = {r[31], (r == 32'h0), c, v};
   endtask

   task automatic single_op(input string tag, input logic [3:0] cmd, input logic s,
                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      exe_cmd = cmd; s_bit = s; val1 = a; val2 = b; valid_in = 1'b1;
      model(cmd, s, a, b, r);
      exp_q.push_back(r);
      tick();
      valid_in = 1'b0;
      chk({tag, ".valid"}, {31'b0, result_valid}, 32'h1);
      chk({tag, ".result"}, result, exp_q.pop_front());
      chk({tag, ".nzcv"}, {28'b0, status_out}, {28'b0, exp_status});
      chk({tag, ".ready"}, {31'b0, ready_out}, 32'h1);
   endtask

`ifdef MUL_UNIT_EN
   // Accept a MUL, watch the 32 busy cycles (with one ignored valid pulse), check the product.
   task automatic mul_op(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int poke_k);
      logic [31:0] r;
      logic [3:0]  busy_status;
      exe_cmd = C_MUL; s_bit = s; val1 = a; val2 = b; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      busy_status = exp_status;
      for (int k = 0; k < 32; k++) begin
         chk({tag, ".busy_ready"}, {31'b0, ready_out}, 32'h0);
         chk({tag, ".busy_valid"}, {31'b0, result_valid}, 32'h0);
         valid_in = (k == poke_k);
         exe_cmd  = (k == poke_k) ? C_ADD : C_MUL;
         s_bit    = 1'b1;
         val1     = $urandom;
         val2     = $urandom;
         tick();
      end
      valid_in = 1'b0;
      chk({tag, ".busy_nzcv"}, {28'b0, status_out}, {28'b0, busy_status});
      model(C_MUL, s, a, b, r);
      exp_q.push_back(r);
      chk({tag, ".valid"}, {31'b0, result_valid}, 32'h1);
      chk({tag, ".ready"}, {31'b0, ready_out}, 32'h1);
      chk({tag, ".result"}, result, exp_q.pop_front());
      chk({tag, ".nzcv"}, {28'b0, status_out}, {28'b0, exp_status});
   endtask
`endif

   task automatic do_op(input string tag, input logic [3:0] cmd, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_UNIT_EN
      if (cmd == C_MUL) mul_op(tag, s, a, b, int'($urandom_range(0, 31)));
      else              single_op(tag, cmd, s, a, b);
`else
      single_op(tag, cmd, s, a, b);
`endif
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int pulses;
      rst = 1'b0; valid_in = 1'b0; exe_cmd = 4'h0; s_bit = 1'b0; val1 = '0; val2 = '0;
      exp_status = 4'b0000;
      tick(); tick();
      chk("rst.result", result, 32'h0);
      chk("rst.valid", {31'b0, result_valid}, 32'h0);
      chk("rst.nzcv", {28'b0, status_out}, 32'h0);
      chk("rst.ready", {31'b0, ready_out}, 32'h1);
      chk("rst.state", {31'b0, dbg_state}, 32'h0);
      rst = 1'b1;
      tick();

      single_op("add_ovf", C_ADD, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
      chk("add_ovf.const_nzcv", {28'b0, status_out}, 32'h9);
      tick();
      chk("add_ovf.pulse_end", {31'b0, result_valid}, 32'h0);

      single_op("sub_eq", C_SUB, 1'b1, 32'd5, 32'd5);
      single_op("adc_wrap", C_ADC, 1'b1, 32'hFFFF_FFFF, 32'h0);
      chk("adc_wrap.const_nzcv", {28'b0, status_out}, 32'h6);
      single_op("sub_nos", C_SUB, 1'b0, 32'd5, 32'd5);
      chk("sub_nos.const_nzcv", {28'b0, status_out}, 32'h6);
      single_op("sub_borrow", C_SUB, 1'b1, 32'd0, 32'd1);
      single_op("sbc_c0", C_SBC, 1'b1, 32'd10, 32'd3);

      single_op("b2b_and", C_AND, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      single_op("b2b_orr", C_ORR, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      single_op("b2b_eor", C_EOR, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      single_op("b2b_mvn", C_MVN, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      chk("b2b_mvn.const", result, 32'hF00F_F00F);
      single_op("undef", 4'b1111, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);

`ifdef MUL_UNIT_EN
      mul_op("mul_plan", 1'b1, 32'h0001_0003, 32'h0000_0007, 13);
      chk("mul_plan.const", result, 32'h0007_0015);
      // Abort a multiply with reset on busy edge E0+10.
      exe_cmd = C_MUL; s_bit = 1'b1; val1 = 32'h0000_0003; val2 = 32'hFFFF_FFFF; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_status = 4'b0000;
      chk("mul_abort.ready", {31'b0, ready_out}, 32'h1);
      chk("mul_abort.result", result, 32'h0);
      chk("mul_abort.nzcv", {28'b0, status_out}, 32'h0);
      chk("mul_abort.state", {31'b0, dbg_state}, 32'h0);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         if (result_valid === 1'b1) pulses++;
         tick();
      end
      chk("mul_abort.no_pulse", pulses, 32'h0);
`else
      single_op("mul_undef", C_MUL, 1'b1, 32'h0001_0003, 32'h0000_0007);
      chk("mul_undef.z", {31'b0, status_out[2]}, 32'h1);
      tick();
      chk("mul_undef.ready_hold", {31'b0, ready_out}, 32'h1);
      chk("mul_undef.pulse_end", {31'b0, result_valid}, 32'h0);
      // Plain reset mid-stream clears result and flags.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_status = 4'b0000;
      chk("mid_rst.result", result, 32'h0);
      chk("mid_rst.nzcv", {28'b0, status_out}, 32'h0);
`endif

      for (int i = 0; i < 150; i++) begin
         logic [3:0] cmd;
         cmd = 4'($urandom_range(0, 15));
         do_op("rand", cmd, 1'($urandom_range(0, 1)), pick_val(), pick_val());
         if ($urandom_range(0, 4) == 0) begin
            tick();
            chk("rand.idle_valid", {31'b0, result_valid}, 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
